// File: rtl/swipt_link_scheduler.sv
// SWIPT transmitter link sequencer: soft-start, sweep, power and data phases, output gating.
// Optional overcurrent trip enabled by defining SWIPT_OCP_TRIP_EN.
module swipt_link_scheduler #(
  parameter int unsigned SOFTSTART_CYCLES = 1000,
  parameter int unsigned SWEEP_TIMEOUT    = 1000000,
  parameter int unsigned DATA_GUARD       = 64,
  parameter logic [11:0] ADC_LIMIT        = 12'hE00,
  parameter int unsigned FAULT_HOLD       = 4096
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        enable,
  input  logic        swipt_alive,
  input  logic [11:0] adc_in,
  input  logic        freq_ready,
  input  logic        freq_opt,
  input  logic        data_req,
  input  logic        data_done,
  output logic        out_en,
  output logic        sweep_start,
  output logic        data_start,
  output logic        duty_ramp,
  output logic [2:0]  state,
  output logic        fault
);

  localparam int unsigned CNT_W = 20;
  localparam logic [CNT_W-1:0] SS_LAST = CNT_W'(SOFTSTART_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(SWEEP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DG_LAST = CNT_W'(DATA_GUARD - 1);
  localparam logic [CNT_W-1:0] FH_LAST = CNT_W'(FAULT_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SOFTSTART = 3'd1,
    S_SWEEP     = 3'd2,
    S_POWER     = 3'd3,
    S_DATA      = 3'd4,
    S_GUARD     = 3'd5,
    S_FAULT     = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_en_q, out_en_d;
  logic             sweep_start_q, sweep_start_d;
  logic             data_start_q, data_start_d;
  logic             duty_ramp_q, duty_ramp_d;
  logic             fault_q, fault_d;
  logic             cnt_clr;
  logic             run;
  logic             active;
  logic             ocp_trip;

  assign run    = enable & swipt_alive;
  assign active = (state_q == S_SOFTSTART) || (state_q == S_SWEEP) || (state_q == S_POWER) ||
                  (state_q == S_DATA) || (state_q == S_GUARD);

`ifdef SWIPT_OCP_TRIP_EN
  // Consecutive over-limit sample counter; the fourth high sample trips.
  logic [1:0] ocp_cnt_q, ocp_cnt_d;
  logic       adc_hi;

  assign adc_hi   = (adc_in >= ADC_LIMIT);
  assign ocp_trip = active && adc_hi && (ocp_cnt_q == 2'd3);

  always_comb begin
    ocp_cnt_d = 2'd0;
    if (active && adc_hi && !ocp_trip) ocp_cnt_d = ocp_cnt_q + 2'd1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) ocp_cnt_q <= 2'd0;
    else       ocp_cnt_q <= ocp_cnt_d;
  end
`else
  logic unused_adc;
  assign unused_adc = ^{adc_in, ADC_LIMIT};
  assign ocp_trip   = 1'b0;
`endif

  // Next-state, strobe and registered-output decode.
  always_comb begin
    state_d       = state_q;
    cnt_clr       = 1'b0;
    sweep_start_d = 1'b0;
    data_start_d  = 1'b0;

    case (state_q)
      S_IDLE: if (run) state_d = S_SOFTSTART;
      S_SOFTSTART: begin
        if (cnt_q >= SS_LAST) begin
          state_d       = S_SWEEP;
          sweep_start_d = 1'b1;
        end
      end
      S_SWEEP: begin
        // freq_ready is ignored in the cycle right after a strobe so strobes never abut
        if (freq_ready && !sweep_start_q) begin
          if (freq_opt) begin
            state_d = S_POWER;
          end else begin
            cnt_clr       = 1'b1;
            sweep_start_d = 1'b1;
          end
        end else if (cnt_q >= TO_LAST) begin
          state_d = S_FAULT;
        end
      end
      S_POWER: begin
        if (data_req) begin
          state_d      = S_DATA;
          data_start_d = 1'b1;
        end
      end
      S_DATA:  if (data_done) state_d = S_GUARD;
      S_GUARD: if (cnt_q >= DG_LAST) state_d = S_POWER;
      S_FAULT: if ((cnt_q >= FH_LAST) && !enable) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (active && !run) begin
      state_d       = S_IDLE;
      cnt_clr       = 1'b0;
      sweep_start_d = 1'b0;
      data_start_d  = 1'b0;
    end

    if (ocp_trip) begin
      state_d       = S_FAULT;
      cnt_clr       = 1'b0;
      sweep_start_d = 1'b0;
      data_start_d  = 1'b0;
    end

    if ((state_d != state_q) || cnt_clr) cnt_d = '0;
    else if (cnt_q == {CNT_W{1'b1}})     cnt_d = cnt_q;
    else                                 cnt_d = cnt_q + CNT_W'(1);

    out_en_d    = (state_d == S_SOFTSTART) || (state_d == S_SWEEP) || (state_d == S_POWER) ||
                  (state_d == S_DATA) || (state_d == S_GUARD);
    duty_ramp_d = (state_d == S_SOFTSTART);
    fault_d     = (state_d == S_FAULT);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      out_en_q      <= 1'b0;
      sweep_start_q <= 1'b0;
      data_start_q  <= 1'b0;
      duty_ramp_q   <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      out_en_q      <= out_en_d;
      sweep_start_q <= sweep_start_d;
      data_start_q  <= data_start_d;
      duty_ramp_q   <= duty_ramp_d;
      fault_q       <= fault_d;
    end
  end

  assign state       = 3'(state_q);
  assign out_en      = out_en_q;
  assign sweep_start = sweep_start_q;
  assign data_start  = data_start_q;
  assign duty_ramp   = duty_ramp_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_swipt_link_scheduler.sv
// Scoreboard bench for swipt_link_scheduler: directed phases, expectations tagged by clock edge.
module tb_swipt_link_scheduler;

  logic        clk = 1'b0;
  logic        nrst;
  logic        enable, swipt_alive, freq_ready, freq_opt, data_req, data_done;
  logic [11:0] adc_in;
  logic        out_en, sweep_start, data_start, duty_ramp, fault;
  logic [2:0]  state;

  swipt_link_scheduler #(
    .SOFTSTART_CYCLES(8),
    .SWEEP_TIMEOUT(100),
    .DATA_GUARD(4),
    .ADC_LIMIT(12'hE00),
    .FAULT_HOLD(16)
  ) dut (
    .clk(clk), .nrst(nrst), .enable(enable), .swipt_alive(swipt_alive), .adc_in(adc_in),
    .freq_ready(freq_ready), .freq_opt(freq_opt), .data_req(data_req), .data_done(data_done),
    .out_en(out_en), .sweep_start(sweep_start), .data_start(data_start),
    .duty_ramp(duty_ramp), .state(state), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    string      name;
    logic [2:0] st;
    logic       oe, ss, ds, dr, ft;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic void expect_at(input int tag, input string nm, input logic [2:0] st,
                                    input logic oe, input logic ss, input logic ds,
                                    input logic dr, input logic ft);
    exp_t e;
    e.tag = tag; e.name = nm; e.st = st;
    e.oe = oe; e.ss = ss; e.ds = ds; e.dr = dr; e.ft = ft;
    sb.push_back(e);
  endfunction

  // Monitor: compare every expectation whose edge tag has been reached.
  initial forever begin
    @(negedge clk);
    while (sb.size() > 0 && sb[0].tag <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      if (e.tag < cyc) begin
        n_bad++;
        $display("FAIL %s: stale expectation for edge %0d seen at edge %0d", e.name, e.tag, cyc);
      end else if ({state, out_en, sweep_start, data_start, duty_ramp, fault} !==
                   {e.st, e.oe, e.ss, e.ds, e.dr, e.ft}) begin
        n_bad++;
        $display("FAIL %s @%0d: got st=%0d oe=%b ss=%b ds=%b dr=%b ft=%b, want st=%0d oe=%b ss=%b ds=%b dr=%b ft=%b",
                 e.name, cyc, state, out_en, sweep_start, data_start, duty_ramp, fault,
                 e.st, e.oe, e.ss, e.ds, e.dr, e.ft);
      end
    end
  end

  // Park on the negedge just before clock edge t so new inputs are sampled at edge t.
  task automatic at_edge(input int t);
    while (cyc < t - 1) @(negedge clk);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time bound at edge %0d", cyc);
    $fatal(1);
  end

  int t0, p, q, r, t, s;

  initial begin
    nrst = 1'b0; enable = 1'b0; swipt_alive = 1'b0; adc_in = 12'h000;
    freq_ready = 1'b0; freq_opt = 1'b0; data_req = 1'b0; data_done = 1'b0;

    @(negedge clk);
    expect_at(cyc + 1, "reset", 3'd0, 0, 0, 0, 0, 0);
    @(negedge clk);
    nrst = 1'b1;

    // Normal startup
    t0 = cyc + 1;
    at_edge(t0);
    enable = 1'b1; swipt_alive = 1'b1;
    expect_at(t0,      "ss_enter",   3'd1, 1, 0, 0, 1, 0);
    expect_at(t0 + 7,  "ss_last",    3'd1, 1, 0, 0, 1, 0);
    expect_at(t0 + 8,  "sweep_strb", 3'd2, 1, 1, 0, 0, 0);
    expect_at(t0 + 9,  "sweep_hold", 3'd2, 1, 0, 0, 0, 0);
    expect_at(t0 + 19, "power",      3'd3, 1, 0, 0, 0, 0);
    at_edge(t0 + 19); freq_ready = 1'b1; freq_opt = 1'b1;
    at_edge(t0 + 20); freq_ready = 1'b0; freq_opt = 1'b0;

    // Data window and guard
    p = t0 + 22;
    expect_at(p,      "data_strb",   3'd4, 1, 0, 1, 0, 0);
    expect_at(p + 1,  "data_hold",   3'd4, 1, 0, 0, 0, 0);
    expect_at(p + 49, "data_wait",   3'd4, 1, 0, 0, 0, 0);
    expect_at(p + 50, "guard_enter", 3'd5, 1, 0, 0, 0, 0);
    expect_at(p + 53, "guard_last",  3'd5, 1, 0, 0, 0, 0);
    expect_at(p + 54, "guard_exit",  3'd3, 1, 0, 0, 0, 0);
    expect_at(p + 55, "data_again",  3'd4, 1, 0, 1, 0, 0);
    expect_at(p + 56, "data_again2", 3'd4, 1, 0, 0, 0, 0);
    at_edge(p);      data_req = 1'b1;
    at_edge(p + 1);  data_req = 1'b0;
    at_edge(p + 50); data_done = 1'b1;
    at_edge(p + 51); data_done = 1'b0;
    at_edge(p + 52); data_req = 1'b1;

    // Heartbeat loss in DATA
    q = p + 60;
    expect_at(q,     "hb_loss",  3'd0, 0, 0, 0, 0, 0);
    expect_at(q + 1, "hb_idle",  3'd0, 0, 0, 0, 0, 0);
    at_edge(q);     swipt_alive = 1'b0;
    at_edge(q + 2); data_req = 1'b0;

    // Sweep retry, timeout, fault hold
    r = q + 3;
    expect_at(r,       "ss2",         3'd1, 1, 0, 0, 1, 0);
    expect_at(r + 8,   "sweep2_strb", 3'd2, 1, 1, 0, 0, 0);
    expect_at(r + 14,  "sweep2_wait", 3'd2, 1, 0, 0, 0, 0);
    expect_at(r + 15,  "retry_strb",  3'd2, 1, 1, 0, 0, 0);
    expect_at(r + 16,  "retry_hold",  3'd2, 1, 0, 0, 0, 0);
    expect_at(r + 114, "pre_timeout", 3'd2, 1, 0, 0, 0, 0);
    expect_at(r + 115, "timeout",     3'd6, 0, 0, 0, 0, 1);
    expect_at(r + 130, "fault_hold",  3'd6, 0, 0, 0, 0, 1);
    expect_at(r + 131, "fault_exit",  3'd0, 0, 0, 0, 0, 0);
    at_edge(r);       swipt_alive = 1'b1;
    at_edge(r + 15);  freq_ready = 1'b1; freq_opt = 1'b0;
    at_edge(r + 16);  freq_ready = 1'b0;
    at_edge(r + 116); enable = 1'b0;

    // Asynchronous reset mid-sweep
    t = r + 133;
    expect_at(t,      "ss3",         3'd1, 1, 0, 0, 1, 0);
    expect_at(t + 8,  "sweep3_strb", 3'd2, 1, 1, 0, 0, 0);
    expect_at(t + 10, "async_rst",   3'd0, 0, 0, 0, 0, 0);
    expect_at(t + 11, "rst_held",    3'd0, 0, 0, 0, 0, 0);
    expect_at(t + 12, "rst_noenable",3'd0, 0, 0, 0, 0, 0);
    expect_at(t + 13, "rst_restart", 3'd1, 1, 0, 0, 1, 0);
    at_edge(t); enable = 1'b1;
    at_edge(t + 10);
    @(posedge clk);
    #2;
    nrst = 1'b0; enable = 1'b0;
    at_edge(t + 12); nrst = 1'b1;
    at_edge(t + 13); enable = 1'b1;

    // Overcurrent
    s = t + 13;
    expect_at(s + 8,  "sweep4_strb", 3'd2, 1, 1, 0, 0, 0);
    expect_at(s + 10, "power4",      3'd3, 1, 0, 0, 0, 0);
    expect_at(s + 15, "ocp_3_low",   3'd3, 1, 0, 0, 0, 0);
    expect_at(s + 18, "ocp_3_high",  3'd3, 1, 0, 0, 0, 0);
`ifdef SWIPT_OCP_TRIP_EN
    expect_at(s + 19, "ocp_trip",    3'd6, 0, 0, 0, 0, 1);
`else
    expect_at(s + 19, "ocp_ignored", 3'd3, 1, 0, 0, 0, 0);
`endif
    at_edge(s + 10); freq_ready = 1'b1; freq_opt = 1'b1;
    at_edge(s + 11); freq_ready = 1'b0; freq_opt = 1'b0;
    at_edge(s + 12); adc_in = 12'hE00;
    at_edge(s + 15); adc_in = 12'h100;
    at_edge(s + 16); adc_in = 12'hFFF;
    at_edge(s + 20); adc_in = 12'h000;
    at_edge(s + 24);
    @(negedge clk);

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL %s: expectation for edge %0d never checked (now %0d)", e.name, e.tag, cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
